// File: rtl/cpu_pkg.sv
// Shared pipeline constants: datapath width, register-address width, PC register index.
package cpu_pkg;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 4;
  localparam int PC_REG     = 15;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory-to-writeback stage bus: memory-stage inputs, hazard controls, writeback outputs.
interface mem_wb_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
);
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] ReadDataM;
  logic [REG_AW-1:0] WA3M;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              ValidM;
  logic              StallW;
  logic              FlushW;
  logic [REG_AW-1:0] RA1E;
  logic [REG_AW-1:0] RA2E;
  logic [DATA_W-1:0] ResultW;
  logic [REG_AW-1:0] WA3W;
  logic              RegWriteW;
  logic              PCWriteW;
  logic              FwdAW;
  logic              FwdBW;
  logic [31:0]       RetiredW;

  modport master (
    output ALUResultM, ReadDataM, WA3M, RegWriteM, MemtoRegM, ValidM,
    output StallW, FlushW, RA1E, RA2E,
    input  ResultW, WA3W, RegWriteW, PCWriteW, FwdAW, FwdBW, RetiredW
  );

  modport slave (
    input  ALUResultM, ReadDataM, WA3M, RegWriteM, MemtoRegM, ValidM,
    input  StallW, FlushW, RA1E, RA2E,
    output ResultW, WA3W, RegWriteW, PCWriteW, FwdAW, FwdBW, RetiredW
  );
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register with load enable and clear; clear beats enable, reset beats both.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (clr)  q <= '0;
    else if (en)   q <= d;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: one-cycle register from memory stage, result select, forward compare, retire count.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic           clk,
  input  logic           reset,
  mem_wb_stage_if.slave  bus
);
  localparam int W = 2 * DATA_W + REG_AW + 3;
  localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

  logic [W-1:0]      stage_d;
  logic [W-1:0]      stage_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  logic [REG_AW-1:0] wa3_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic              valid_q;
  logic              reg_write;
  logic [31:0]       retired_q;

  assign stage_d = {bus.ALUResultM, bus.ReadDataM, bus.WA3M,
                    bus.RegWriteM, bus.MemtoRegM, bus.ValidM};
  assign {alu_q, rdata_q, wa3_q, regwrite_q, memtoreg_q, valid_q} = stage_q;

  pipe_reg #(.W(W)) u_stage (
    .clk   (clk),
    .reset (reset),
    .en    (~bus.StallW),
    .clr   (bus.FlushW),
    .d     (stage_d),
    .q     (stage_q)
  );

  assign reg_write     = valid_q & regwrite_q;
  assign bus.ResultW   = memtoreg_q ? rdata_q : alu_q;
  assign bus.WA3W      = wa3_q;
  assign bus.RegWriteW = reg_write;
  assign bus.PCWriteW  = reg_write & (wa3_q == PC_IDX);
  // R15 reads are served by the PC path, never by the writeback forward.
  assign bus.FwdAW     = reg_write & (wa3_q == bus.RA1E) & (bus.RA1E != PC_IDX);
  assign bus.FwdBW     = reg_write & (wa3_q == bus.RA2E) & (bus.RA2E != PC_IDX);

  // An instruction retires on the edge it leaves the stage, so a stalled one counts once.
  always_ff @(posedge clk) begin
    if (reset)
      retired_q <= '0;
    else if (valid_q & ~bus.StallW & ~bus.FlushW)
      retired_q <= retired_q + 32'd1;
  end

  assign bus.RetiredW = retired_q;
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 4, register-address width (16 ARM registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ALUResultM  input  DATA_W  address/ALU value from the memory stage.
REQ-006 SHALL have port ReadDataM  input  DATA_W  data-memory read value, valid in the same cycle as ALUResultM.
REQ-007 SHALL have port WA3M  input  REG_AW  destination register.
REQ-008 SHALL have port RegWriteM, MemtoRegM, ValidM  input  1 each  control bits for the instruction in the memory stage.
REQ-009 SHALL have port StallW, FlushW  input  1 each  hazard-unit controls.
REQ-010 SHALL have port RA1E, RA2E  input  REG_AW each  execute-stage source registers for forward compare.
REQ-011 SHALL have port ResultW  output  DATA_W  register-file write data.
REQ-012 SHALL have port WA3W  output  REG_AW  register-file write address.
REQ-013 SHALL have port RegWriteW  output  1  register-file write enable.
REQ-014 SHALL have port PCWriteW  output  1  write targets R15 (PC).
REQ-015 SHALL have port FwdAW, FwdBW  output  1 each  forward ResultW to execute operand A/B.
REQ-016 SHALL have port RetiredW  output  32  retired-instruction counter.

Function
REQ-017 SHALL capture ALUResultM, ReadDataM, WA3M, RegWriteM, MemtoRegM, ValidM into stage registers on each edge with StallW=0 and FlushW=0 (latency exactly one cycle).
REQ-018 SHALL hold all stage registers unchanged on an edge with StallW=1 and FlushW=0.
REQ-019 SHALL, on an edge with FlushW=1, clear valid_q and RegWrite_q to 0 (bubble) regardless of StallW; data fields are don't-care.
REQ-020 SHALL drive ResultW combinationally as ReadData_q when MemtoReg_q=1, else ALUResult_q.
REQ-021 SHALL drive WA3W = WA3_q and RegWriteW = valid_q AND RegWrite_q.
REQ-022 SHALL drive PCWriteW = RegWriteW AND (WA3_q == 15).
REQ-023 SHALL drive FwdAW = RegWriteW AND (WA3_q == RA1E) AND (RA1E != 15); FwdBW likewise with RA2E.
REQ-024 SHALL increment RetiredW by 1 on each edge where valid_q=1 and StallW=0 and FlushW=0, wrapping 0xFFFFFFFF -> 0.
REQ-025 SHALL NOT count an instruction held by StallW more than once; a flush discards the held instruction uncounted.
REQ-026 SHALL, with ValidM=0 captured, produce RegWriteW=0, PCWriteW=0, FwdAW=FwdBW=0.

Reset
REQ-027 SHALL, on an edge with reset=1, clear all stage registers and RetiredW to 0, overriding StallW and FlushW.
REQ-028 SHALL, after reset, output ResultW=0, WA3W=0, RegWriteW=0, PCWriteW=0, FwdAW=FwdBW=0, RetiredW=0.
REQ-029 SHALL discard an instruction present at reset assertion mid-stall; it is never written or counted.

Structure
REQ-030 SHALL take DATA_W, REG_AW and the PC register index (15) from the shared pipeline package cpu_pkg.
REQ-031 SHALL place the stall/flush-capable register in one sub-module pipe_reg (parameterised width, en, clr); muxes, compares and counter stay in mem_wb_stage.

Verification
REQ-032 Load: ReadDataM=0xDEADBEEF, ALUResultM=0x100, MemtoRegM=1, RegWriteM=1, ValidM=1, WA3M=3 -> next cycle ResultW=0xDEADBEEF, WA3W=3, RegWriteW=1, RetiredW increments one cycle later.
REQ-033 ALU op: MemtoRegM=0, ALUResultM=0x5, WA3M=15, RegWriteM=1 -> ResultW=0x5, PCWriteW=1, FwdAW=0 even with RA1E=15.
REQ-034 Stall 3 cycles with new inputs applied -> outputs frozen at prior values, RetiredW increments exactly once after release.
REQ-035 FlushW=1 and StallW=1 same edge -> RegWriteW=0 next cycle, RetiredW unchanged.
REQ-036 Forward: WA3_q=7, RegWriteW=1, RA1E=7, RA2E=2 -> FwdAW=1, FwdBW=0; counter preset near 0xFFFFFFFF retires one -> RetiredW=0.
REQ-037 reset=1 during stall with valid instruction -> all outputs 0 next cycle, held instruction not written.
